// File: rtl/pwm_timebase_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_timebase_ctrl
//
// Timebase and update scheduler for the PWM generation datapath.
//
// This block generates the prescaled tick and the period counter that the
// PWM generator uses. It also holds the active per-channel edge and enable
// registers. Values written by software into the shadow registers move into
// the active registers in one of two ways:
//   - immediate mode: on the next clock edge;
//   - synchronous mode: only on the last tick of a period.
// In synchronous mode a channel never changes its edges partway through a
// period.
//
// Ports
//   PCLK                system clock, rising edge
//   PRESETN             asynchronous active-low reset
//   timebase_en         1 = counters run, 0 = counters held at 0
//   prescale_reg        a tick occurs every prescale_reg+1 cycles
//   period_reg          period_cnt counts 0..period_reg
//   sync_update_en      1 = shadow loads at period end, 0 = immediate
//   shadow_wr           one-cycle pulse, shadow contents already valid
//   pwm_posedge_shadow  software rising-edge values (PWM_NUM lanes)
//   pwm_negedge_shadow  software falling-edge values (PWM_NUM lanes)
//   pwm_enable_shadow   software channel enables
//   period_cnt          current period count
//   sync_pulse          prescaled tick
//   period_end          last tick of the period
//   pwm_posedge_reg     active rising-edge values
//   pwm_negedge_reg     active falling-edge values
//   pwm_enable_reg      active channel enables
//   update_pending      a shadow write is waiting for period end
// ---------------------------------------------------------------------------
module pwm_timebase_ctrl #(
    parameter int PWM_NUM    = 8,
    parameter int APB_DWIDTH = 8
) (
    input  logic                          PCLK,
    input  logic                          PRESETN,
    input  logic                          timebase_en,
    input  logic [APB_DWIDTH-1:0]         prescale_reg,
    input  logic [APB_DWIDTH-1:0]         period_reg,
    input  logic                          sync_update_en,
    input  logic                          shadow_wr,
    input  logic [PWM_NUM*APB_DWIDTH-1:0] pwm_posedge_shadow,
    input  logic [PWM_NUM*APB_DWIDTH-1:0] pwm_negedge_shadow,
    input  logic [PWM_NUM-1:0]            pwm_enable_shadow,
    output logic [APB_DWIDTH-1:0]         period_cnt,
    output logic                          sync_pulse,
    output logic                          period_end,
    output logic [PWM_NUM*APB_DWIDTH-1:0] pwm_posedge_reg,
    output logic [PWM_NUM*APB_DWIDTH-1:0] pwm_negedge_reg,
    output logic [PWM_NUM-1:0]            pwm_enable_reg,
    output logic                          update_pending
);

    localparam logic [APB_DWIDTH-1:0] CNT_ONE = {{(APB_DWIDTH-1){1'b0}}, 1'b1};

    logic [APB_DWIDTH-1:0] pre_cnt;
    logic                  imm_load;
    logic                  load_active;

    // The ">=" compares make the counters wrap on the next tick after
    // software shrinks a limit below the current count. Without them a
    // counter would run all the way to 2^APB_DWIDTH before wrapping.
    assign sync_pulse = timebase_en && (pre_cnt >= prescale_reg);
    assign period_end = sync_pulse && (period_cnt >= period_reg);

    // When the timebase is stopped, no period end will ever arrive. In that
    // case a pending or new write loads at once.
    assign imm_load    = !sync_update_en || !timebase_en;
    assign load_active = (shadow_wr || update_pending) && (imm_load || period_end);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            pre_cnt <= '0;
        end else if (!timebase_en || sync_pulse) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            period_cnt <= '0;
        end else if (!timebase_en) begin
            period_cnt <= '0;
        end else if (period_end) begin
            period_cnt <= '0;
        end else if (sync_pulse) begin
            period_cnt <= period_cnt + CNT_ONE;
        end
    end

    // All three active groups load together so that a channel never sees
    // new edges with a stale enable, or the reverse.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            pwm_posedge_reg <= '0;
            pwm_negedge_reg <= '0;
            pwm_enable_reg  <= '0;
            update_pending  <= 1'b0;
        end else if (load_active) begin
            pwm_posedge_reg <= pwm_posedge_shadow;
            pwm_negedge_reg <= pwm_negedge_shadow;
            pwm_enable_reg  <= pwm_enable_shadow;
            update_pending  <= 1'b0;
        end else if (shadow_wr) begin
            update_pending  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
module tb_pwm_timebase_ctrl;

    localparam int N = 8;
    localparam int W = 8;

    logic           PCLK = 1'b0;
    logic           PRESETN;
    logic           timebase_en;
    logic [W-1:0]   prescale_reg;
    logic [W-1:0]   period_reg;
    logic           sync_update_en;
    logic           shadow_wr;
    logic [N*W-1:0] pwm_posedge_shadow;
    logic [N*W-1:0] pwm_negedge_shadow;
    logic [N-1:0]   pwm_enable_shadow;
    logic [W-1:0]   period_cnt;
    logic           sync_pulse;
    logic           period_end;
    logic [N*W-1:0] pwm_posedge_reg;
    logic [N*W-1:0] pwm_negedge_reg;
    logic [N-1:0]   pwm_enable_reg;
    logic           update_pending;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_timebase_ctrl #(.PWM_NUM(N), .APB_DWIDTH(W)) dut (
        .PCLK               (PCLK),
        .PRESETN            (PRESETN),
        .timebase_en        (timebase_en),
        .prescale_reg       (prescale_reg),
        .period_reg         (period_reg),
        .sync_update_en     (sync_update_en),
        .shadow_wr          (shadow_wr),
        .pwm_posedge_shadow (pwm_posedge_shadow),
        .pwm_negedge_shadow (pwm_negedge_shadow),
        .pwm_enable_shadow  (pwm_enable_shadow),
        .period_cnt         (period_cnt),
        .sync_pulse         (sync_pulse),
        .period_end         (period_end),
        .pwm_posedge_reg    (pwm_posedge_reg),
        .pwm_negedge_reg    (pwm_negedge_reg),
        .pwm_enable_reg     (pwm_enable_reg),
        .update_pending     (update_pending)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic at_drive();
        @(posedge PCLK);
        #1;
    endtask

    task automatic at_sample();
        @(negedge PCLK);
    endtask

    // Behavioural model. It tracks the prescale count and the period count
    // as integers. It also keeps a copy of the active values and a pending
    // flag.
    int             m_pre, m_per;
    logic [N*W-1:0] m_pos, m_neg;
    logic [N-1:0]   m_en;
    bit             m_pend;

    always @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            m_pre  <= 0;
            m_per  <= 0;
            m_pos  <= '0;
            m_neg  <= '0;
            m_en   <= '0;
            m_pend <= 1'b0;
        end else begin
            bit tick, last, want, may;
            tick = timebase_en && (m_pre >= int'(prescale_reg));
            last = tick && (m_per >= int'(period_reg));
            m_pre <= (!timebase_en || tick) ? 0 : m_pre + 1;
            if (!timebase_en || last) m_per <= 0;
            else if (tick)            m_per <= m_per + 1;
            want = shadow_wr || m_pend;
            may  = !sync_update_en || !timebase_en || last;
            if (want && may) begin
                m_pos  <= pwm_posedge_shadow;
                m_neg  <= pwm_negedge_shadow;
                m_en   <= pwm_enable_shadow;
                m_pend <= 1'b0;
            end else if (shadow_wr) begin
                m_pend <= 1'b1;
            end
        end
    end

    always @(negedge PCLK) begin
        if (PRESETN === 1'b1) begin
            bit e_sync, e_end;
            e_sync = timebase_en && (m_pre >= int'(prescale_reg));
            e_end  = e_sync && (m_per >= int'(period_reg));
            check("model_period_cnt", 64'(period_cnt), 64'(m_per));
            check("model_sync_pulse", 64'(sync_pulse), 64'(e_sync));
            check("model_period_end", 64'(period_end), 64'(e_end));
            check("model_posedge_reg", pwm_posedge_reg, m_pos);
            check("model_negedge_reg", pwm_negedge_reg, m_neg);
            check("model_enable_reg", 64'(pwm_enable_reg), 64'(m_en));
            check("model_pending", 64'(update_pending), 64'(m_pend));
        end
    end

    initial begin
        #(200000 * 10);
        timeout("global_watchdog");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        PRESETN            = 1'b0;
        timebase_en        = 1'b0;
        prescale_reg       = '0;
        period_reg         = '0;
        sync_update_en     = 1'b0;
        shadow_wr          = 1'b0;
        pwm_posedge_shadow = '0;
        pwm_negedge_shadow = '0;
        pwm_enable_shadow  = '0;
        repeat (3) at_sample();
        check("rst_period_cnt", 64'(period_cnt), 0);
        check("rst_sync_pulse", 64'(sync_pulse), 0);
        check("rst_period_end", 64'(period_end), 0);
        check("rst_posedge_reg", pwm_posedge_reg, 0);
        check("rst_enable_reg", 64'(pwm_enable_reg), 0);
        check("rst_pending", 64'(update_pending), 0);
        at_drive();
        PRESETN = 1'b1;

        // Basic tick and period sequence.
        at_drive();
        timebase_en  = 1'b1;
        prescale_reg = 8'd2;
        period_reg   = 8'd3;
        for (int k = 0; k < 5; k++) begin
            t = 0;
            do begin at_sample(); t++; end while (!sync_pulse && t < 10);
            if (!sync_pulse) timeout("tick_wait");
            check("tick_gap", 64'(t), 3);
            check("tick_period_cnt", 64'(period_cnt), 64'(k % 4));
            check("tick_period_end", 64'(period_end), 64'(k == 3));
        end

        // Zero prescale and zero period.
        at_drive();
        prescale_reg = 8'd0;
        period_reg   = 8'd0;
        repeat (3) at_sample();
        for (int k = 0; k < 4; k++) begin
            at_sample();
            check("zero_sync_pulse", 64'(sync_pulse), 1);
            check("zero_period_cnt", 64'(period_cnt), 0);
            check("zero_period_end", 64'(period_end), 1);
        end

        // Sync mode: the write waits for the period end.
        at_drive();
        prescale_reg   = 8'd2;
        period_reg     = 8'd3;
        sync_update_en = 1'b1;
        t = 0;
        do begin at_sample(); t++; end while (!(period_cnt == 8'd1 && !sync_pulse) && t < 50);
        if (t >= 50) timeout("sync_cnt1_wait");
        at_drive();
        pwm_posedge_shadow[15:8] = 8'h10;
        shadow_wr = 1'b1;
        at_drive();
        shadow_wr = 1'b0;
        at_sample();
        check("sync_pending_set", 64'(update_pending), 1);
        check("sync_pos_hold", 64'(pwm_posedge_reg[15:8]), 0);
        t = 0;
        do begin at_sample(); t++; end while (!period_end && t < 20);
        if (!period_end) timeout("sync_end_wait");
        check("sync_pos_hold_end", 64'(pwm_posedge_reg[15:8]), 0);
        check("sync_pending_end", 64'(update_pending), 1);
        at_sample();
        check("sync_pos_loaded", 64'(pwm_posedge_reg[15:8]), 64'h10);
        check("sync_pending_clr", 64'(update_pending), 0);

        // Immediate mode: the write loads on the edge that samples it.
        at_drive();
        sync_update_en    = 1'b0;
        pwm_enable_shadow = 8'hFF;
        shadow_wr         = 1'b1;
        at_sample();
        check("imm_pending_pre", 64'(update_pending), 0);
        at_drive();
        shadow_wr = 1'b0;
        at_sample();
        check("imm_enable_loaded", 64'(pwm_enable_reg), 64'hFF);
        check("imm_pending", 64'(update_pending), 0);

        // Shrinking the period below the current count forces a wrap.
        at_drive();
        prescale_reg = 8'd3;
        period_reg   = 8'd7;
        t = 0;
        do begin at_sample(); t++; end while (!(period_cnt == 8'd5 && !sync_pulse) && t < 300);
        if (t >= 300) timeout("shrink_cnt5_wait");
        at_drive();
        period_reg = 8'd2;
        t = 0;
        do begin at_sample(); t++; end while (!sync_pulse && t < 10);
        if (!sync_pulse) timeout("shrink_tick_wait");
        check("shrink_period_end", 64'(period_end), 1);
        check("shrink_cnt_at_tick", 64'(period_cnt), 5);
        at_sample();
        check("shrink_cnt_wrapped", 64'(period_cnt), 0);

        // A pending write loads on the next edge when the timebase stops.
        at_drive();
        sync_update_en = 1'b1;
        period_reg     = 8'd7;
        t = 0;
        do begin at_sample(); t++; end while (!(period_cnt == 8'd1 && !sync_pulse) && t < 300);
        if (t >= 300) timeout("dis_cnt1_wait");
        at_drive();
        pwm_negedge_shadow = 64'h5555_5555_5555_5555;
        pwm_enable_shadow  = 8'h0F;
        shadow_wr          = 1'b1;
        at_drive();
        shadow_wr = 1'b0;
        at_sample();
        check("dis_pending_set", 64'(update_pending), 1);
        check("dis_enable_hold", 64'(pwm_enable_reg), 64'hFF);
        at_drive();
        timebase_en = 1'b0;
        at_sample();
        check("dis_sync_low", 64'(sync_pulse), 0);
        at_sample();
        check("dis_period_cnt", 64'(period_cnt), 0);
        check("dis_enable_loaded", 64'(pwm_enable_reg), 64'h0F);
        check("dis_neg_loaded", pwm_negedge_reg, 64'h5555_5555_5555_5555);
        check("dis_pending_clr", 64'(update_pending), 0);

        // A reset in the middle of a period discards the pending write.
        at_drive();
        timebase_en = 1'b1;
        t = 0;
        do begin at_sample(); t++; end while (!(period_cnt == 8'd1 && !sync_pulse) && t < 300);
        if (t >= 300) timeout("rst_cnt1_wait");
        at_drive();
        pwm_enable_shadow = 8'hA5;
        shadow_wr         = 1'b1;
        at_drive();
        shadow_wr = 1'b0;
        at_sample();
        check("rstmid_pending_set", 64'(update_pending), 1);
        #2;
        PRESETN = 1'b0;
        #1;
        check("rstmid_period_cnt", 64'(period_cnt), 0);
        check("rstmid_sync", 64'(sync_pulse), 0);
        check("rstmid_end", 64'(period_end), 0);
        check("rstmid_pos", pwm_posedge_reg, 0);
        check("rstmid_neg", pwm_negedge_reg, 0);
        check("rstmid_enable", 64'(pwm_enable_reg), 0);
        check("rstmid_pending", 64'(update_pending), 0);
        at_drive();
        at_drive();
        PRESETN = 1'b1;

        // Randomized traffic, checked against the model on every cycle.
        for (int c = 0; c < 4000; c++) begin
            at_drive();
            PRESETN      = ($urandom_range(0, 599) != 0);
            timebase_en  = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 15) == 0) prescale_reg = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) period_reg   = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) sync_update_en = ~sync_update_en;
            shadow_wr = ($urandom_range(0, 7) == 0);
            pwm_posedge_shadow = {$urandom, $urandom};
            pwm_negedge_shadow = {$urandom, $urandom};
            pwm_enable_shadow  = 8'($urandom);
        end
        at_drive();
        PRESETN   = 1'b1;
        shadow_wr = 1'b0;
        repeat (2) at_sample();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
